// File: rtl/i2c_expander_pkg.sv
// i2c_expander_pkg: shared state encoding, register map, reset values and pointer helper
package i2c_expander_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } state_e;

    localparam logic [7:0] REG_IODIR = 8'h00;
    localparam logic [7:0] REG_IPOL  = 8'h01;
    localparam logic [7:0] REG_GPPU  = 8'h06;
    localparam logic [7:0] REG_GPIO  = 8'h09;
    localparam logic [7:0] REG_OLAT  = 8'h0A;
    localparam logic [7:0] REG_LAST  = 8'h0A;

    localparam logic [7:0] IODIR_RST = 8'hFF;
    localparam logic [7:0] IPOL_RST  = 8'h00;
    localparam logic [7:0] GPPU_RST  = 8'h00;
    localparam logic [7:0] OLAT_RST  = 8'h00;

    // Auto-increment wraps at the top of the map; out-of-map pointers count on modulo 256
    function automatic logic [7:0] ptr_inc(input logic [7:0] p);
        return (p == REG_LAST) ? 8'h00 : p + 8'h01;
    endfunction

endpackage

// File: rtl/i2c_expander_target_bus_sync.sv
// i2c_bus_sync: synchronises scl/sda and flags START, STOP and scl edges
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic                   scl_s;

    // Shift the raw pins through the synchroniser and remember the last settled levels
    always_comb begin
        scl_sync_d = (scl_sync_q << 1) | SYNC_STAGES'(scl);
        sda_sync_d = (sda_sync_q << 1) | SYNC_STAGES'(sda_in);
        scl_s      = scl_sync_q[SYNC_STAGES-1];
        sda_s      = sda_sync_q[SYNC_STAGES-1];
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
        scl_rise   = scl_s & ~scl_prev_q;
        scl_fall   = ~scl_s & scl_prev_q;
        start_det  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
        stop_det   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    end

    // Idle bus level is high, so every stage resets to 1 to avoid a false edge
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

endmodule

// File: rtl/i2c_expander_target.sv
// i2c_expander_target: I2C target with an MCP23008-style GPIO register map
module i2c_expander_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h20,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] gpio_in,
    output logic [7:0] gpio_out,
    output logic [7:0] iodir,
    output logic       busy
);

    import i2c_expander_pkg::*;

    logic       sda_s, scl_rise, scl_fall, start_det, stop_det, byte_go;
    logic [7:0] rd_data;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shreg_q, shreg_d, tx_q, tx_d, ptr_q, ptr_d;
    logic       byte_done_q, byte_done_d, nack_q, nack_d, oe_q, oe_d;
    logic [7:0] iodir_q, iodir_d, ipol_q, ipol_d, gppu_q, gppu_d, olat_q, olat_d;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda_in    (sda_in),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    // Register read mux; GPIO reflects the live pins with polarity inversion applied
    always_comb begin
        rd_data = 8'h00;
        case (ptr_q)
            REG_IODIR: rd_data = iodir_q;
            REG_IPOL:  rd_data = ipol_q;
            REG_GPPU:  rd_data = gppu_q;
            REG_GPIO:  rd_data = gpio_in ^ ipol_q;
            REG_OLAT:  rd_data = olat_q;
            default:   rd_data = 8'h00;
        endcase
    end

    // Protocol FSM: bit shifting, ACK timing, pointer handling and register writes
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        byte_done_d = 1'b0;
        nack_d      = nack_q;
        oe_d        = oe_q;
        iodir_d     = iodir_q;
        ipol_d      = ipol_q;
        gppu_d      = gppu_q;
        olat_d      = olat_q;
        byte_go     = byte_done_q & ~start_det & ~stop_det;
        if (scl_rise && (state_q inside {ADDR, PTR, WDATA, RDATA})) begin
            shreg_d     = {shreg_q[6:0], sda_s};
            cnt_d       = cnt_q + 3'd1;
            byte_done_d = (cnt_q == 3'd7);
        end
        case (state_q)
            ADDR: if (byte_go) state_d = (shreg_q[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
            PTR: if (byte_go) begin
                ptr_d   = shreg_q;
                state_d = PTR_ACK;
            end
            WDATA: if (byte_go) begin
                if (ptr_q == REG_IODIR) iodir_d = shreg_q;
                if (ptr_q == REG_IPOL) ipol_d = shreg_q;
                if (ptr_q == REG_GPPU) gppu_d = shreg_q;
                if (ptr_q == REG_GPIO || ptr_q == REG_OLAT) olat_d = shreg_q;
                ptr_d   = ptr_inc(ptr_q);
                state_d = WDATA_ACK;
            end
            // First fall after the byte starts the ACK, the second ends it
            ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                if (!oe_q) begin
                    oe_d = 1'b1;
                end else if (state_q == ADDR_ACK && shreg_q[0]) begin
                    tx_d    = rd_data;
                    oe_d    = ~rd_data[7];
                    state_d = RDATA;
                end else begin
                    oe_d    = 1'b0;
                    state_d = (state_q == ADDR_ACK) ? PTR : WDATA;
                end
            end
            // cnt wraps to 0 after the 8th rise, marking the end of the byte
            RDATA: if (scl_fall) begin
                if (cnt_q == 3'd0) begin
                    oe_d    = 1'b0;
                    state_d = RDATA_ACK;
                end else begin
                    tx_d = tx_q << 1;
                    oe_d = ~tx_q[6];
                end
            end
            RDATA_ACK: if (scl_rise) begin
                nack_d = sda_s;
                ptr_d  = ptr_inc(ptr_q);
            end else if (scl_fall) begin
                if (nack_q) begin
                    state_d = IGNORE;
                end else begin
                    tx_d    = rd_data;
                    oe_d    = ~rd_data[7];
                    cnt_d   = 3'd0;
                    state_d = RDATA;
                end
            end
            default: ;
        endcase
        if (start_det) begin
            state_d     = ADDR;
            cnt_d       = 3'd0;
            oe_d        = 1'b0;
            byte_done_d = 1'b0;
        end else if (stop_det) begin
            state_d     = IDLE;
            oe_d        = 1'b0;
            byte_done_d = 1'b0;
        end
    end

    // State and register file; the pointer deliberately survives STOP
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            shreg_q     <= 8'h00;
            tx_q        <= 8'h00;
            ptr_q       <= 8'h00;
            byte_done_q <= 1'b0;
            nack_q      <= 1'b0;
            oe_q        <= 1'b0;
            iodir_q     <= IODIR_RST;
            ipol_q      <= IPOL_RST;
            gppu_q      <= GPPU_RST;
            olat_q      <= OLAT_RST;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            byte_done_q <= byte_done_d;
            nack_q      <= nack_d;
            oe_q        <= oe_d;
            iodir_q     <= iodir_d;
            ipol_q      <= ipol_d;
            gppu_q      <= gppu_d;
            olat_q      <= olat_d;
        end
    end

    assign sda_oe   = oe_q;
    assign gpio_out = olat_q;
    assign iodir    = iodir_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_expander_target.sv
// tb_i2c_expander_target: directed I2C controller transactions against the expander
module tb_i2c_expander_target;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       sda_drv = 1'b1;
    logic [7:0] gpio_in = 8'h00;
    logic       sda_oe, busy, sda_line;
    logic [7:0] gpio_out, iodir;
    logic       mon_en = 1'b0;
    logic       oe_seen = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;

    assign sda_line = sda_drv & ~sda_oe;

    i2c_expander_target #(.DEV_ADDR(7'h20), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .iodir    (iodir),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) oe_seen <= mon_en ? (oe_seen | sda_oe) : 1'b0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
        end
    endtask

    task automatic i2c_start;
        sda_drv = 1'b1; tick(Q);
        scl = 1'b1;     tick(Q);
        sda_drv = 1'b0; tick(Q);
        scl = 1'b0;     tick(Q);
    endtask

    task automatic i2c_stop;
        sda_drv = 1'b0; tick(Q);
        scl = 1'b1;     tick(Q);
        sda_drv = 1'b1; tick(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b; tick(Q);
        scl = 1'b1;  tick(2 * Q);
        scl = 1'b0;  tick(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_drv = 1'b1; tick(Q);
        scl = 1'b1;     tick(Q);
        b = sda_line;   tick(Q);
        scl = 1'b0;     tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) recv_bit(b[i]);
        send_bit(nack);
    endtask

    initial begin
        logic       a0, a1, a2;
        logic [7:0] d0, d1, d2;
        logic [7:0] part;
        tick(4);
        reset = 1'b0;
        tick(4);
        check("rst gpio_out", gpio_out, 8'h00);
        check("rst iodir", iodir, 8'hFF);
        check("rst sda_oe", sda_oe, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst ptr", dut.ptr_q, 8'h00);

        i2c_start;
        check("busy after start", busy, 1'b1);
        write_byte(8'h40, a0);
        write_byte(8'h0A, a1);
        write_byte(8'h5A, a2);
        i2c_stop;
        check("olat addr ack", a0, 1'b0);
        check("olat ptr ack", a1, 1'b0);
        check("olat data ack", a2, 1'b0);
        check("olat gpio_out", gpio_out, 8'h5A);
        check("olat ptr wrap", dut.ptr_q, 8'h00);
        check("olat busy", busy, 1'b0);

        i2c_start;
        write_byte(8'h40, a0);
        write_byte(8'h01, a1);
        write_byte(8'h0F, a2);
        i2c_stop;
        gpio_in = 8'h3C;
        i2c_start;
        write_byte(8'h40, a0);
        write_byte(8'h09, a1);
        i2c_start;
        write_byte(8'h41, a2);
        read_byte(1'b1, d0);
        check("gpio rd addr ack", a2, 1'b0);
        check("gpio rd data", d0, 8'h33);
        check("gpio rd busy", busy, 1'b1);
        i2c_stop;
        check("gpio rd busy stop", busy, 1'b0);
        check("gpio rd ptr", dut.ptr_q, 8'h0A);

        mon_en = 1'b1;
        i2c_start;
        write_byte(8'h42, a0);
        write_byte(8'h55, a1);
        i2c_stop;
        check("foreign sda_oe", oe_seen, 1'b0);
        mon_en = 1'b0;
        check("foreign addr nack", a0, 1'b1);
        check("foreign data nack", a1, 1'b1);
        check("foreign gpio_out", gpio_out, 8'h5A);
        check("foreign iodir", iodir, 8'hFF);

        i2c_start;
        write_byte(8'h40, a0);
        write_byte(8'h0A, a1);
        part = 8'h50;
        for (int i = 7; i >= 4; i--) send_bit(part[i]);
        i2c_stop;
        check("partial gpio_out", gpio_out, 8'h5A);
        i2c_start;
        write_byte(8'h40, a0);
        write_byte(8'h0A, a1);
        write_byte(8'hC3, a2);
        i2c_stop;
        check("after partial ack", a2, 1'b0);
        check("after partial gpio_out", gpio_out, 8'hC3);

        i2c_start;
        write_byte(8'h40, a0);
        write_byte(8'h00, a1);
        write_byte(8'h0F, a2);
        i2c_stop;
        check("iodir write", iodir, 8'h0F);
        check("iodir ptr", dut.ptr_q, 8'h01);

        i2c_start;
        write_byte(8'h40, a0);
        write_byte(8'h03, a1);
        write_byte(8'h77, a2);
        i2c_stop;
        check("reserved wr ack", a2, 1'b0);
        i2c_start;
        write_byte(8'h40, a0);
        write_byte(8'h03, a1);
        i2c_start;
        write_byte(8'h41, a2);
        read_byte(1'b1, d0);
        i2c_stop;
        check("reserved rd", d0, 8'h00);
        check("reserved ptr", dut.ptr_q, 8'h04);

        i2c_start;
        write_byte(8'h40, a0);
        write_byte(8'h20, a1);
        write_byte(8'h99, a2);
        i2c_stop;
        check("oob ptr ack", a1, 1'b0);
        check("oob data ack", a2, 1'b0);
        check("oob ptr inc", dut.ptr_q, 8'h21);
        check("oob gpio_out", gpio_out, 8'hC3);
        check("oob iodir", iodir, 8'h0F);

        i2c_start;
        part = 8'h40;
        for (int i = 7; i >= 0; i--) send_bit(part[i]);
        sda_drv = 1'b1;
        tick(Q);
        check("ack driven", sda_oe, 1'b1);
        scl = 1'b1;
        tick(Q);
        reset = 1'b1;
        tick(1);
        check("reset sda_oe", sda_oe, 1'b0);
        reset = 1'b0;
        tick(Q);
        scl = 1'b0;
        tick(Q);
        write_byte(8'h0A, a0);
        write_byte(8'h99, a1);
        i2c_stop;
        check("post reset nack0", a0, 1'b1);
        check("post reset nack1", a1, 1'b1);
        check("post reset gpio_out", gpio_out, 8'h00);
        check("post reset iodir", iodir, 8'hFF);
        check("post reset ptr", dut.ptr_q, 8'h00);
        check("post reset busy", busy, 1'b0);

        i2c_start;
        write_byte(8'h40, a0);
        write_byte(8'h00, a1);
        i2c_start;
        write_byte(8'h41, a2);
        read_byte(1'b0, d0);
        read_byte(1'b0, d1);
        read_byte(1'b1, d2);
        i2c_stop;
        check("burst addr ack", a2, 1'b0);
        check("burst rd0", d0, 8'hFF);
        check("burst rd1", d1, 8'h00);
        check("burst rd2", d2, 8'h00);
        check("burst ptr", dut.ptr_q, 8'h03);

        i2c_start;
        write_byte(8'h40, a0);
        write_byte(8'h09, a1);
        i2c_start;
        write_byte(8'h41, a2);
        read_byte(1'b1, d0);
        i2c_stop;
        check("ipol rst gpio rd", d0, 8'h3C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
